// File: rtl/map_pkg.sv
// Shared tile-map definitions: sprite codes, field widths, map size defaults
// and the responder state encoding.
package map_pkg;
  localparam int COORD_W       = 5;
  localparam int SPRITE_W      = 3;
  localparam int DOTS_W        = 10;
  localparam int MAP_W_DEFAULT = 21;
  localparam int MAP_H_DEFAULT = 21;

  typedef logic [SPRITE_W-1:0] sprite_t;
  typedef logic [COORD_W-1:0]  coord_t;

  localparam sprite_t EMPTY = 3'b000;
  localparam sprite_t DOT   = 3'b001;
  localparam sprite_t WALL  = 3'b011;

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESPOND} map_state_t;
endpackage

// File: rtl/map_responder_if.sv
// Tile-map request/response bundle between the movers (master) and the
// map responder (slave); per-client fields are packed side by side.
interface map_responder_if #(parameter int NUM_CLIENTS = 4);
  import map_pkg::*;

  logic [NUM_CLIENTS-1:0]          req;
  logic [NUM_CLIENTS-1:0]          we;
  logic [COORD_W*NUM_CLIENTS-1:0]  req_x;
  logic [COORD_W*NUM_CLIENTS-1:0]  req_y;
  logic [SPRITE_W*NUM_CLIENTS-1:0] wdata;
  logic [NUM_CLIENTS-1:0]          ack;
  sprite_t                         rdata;

  modport master (output req, we, req_x, req_y, wdata, input ack, rdata);
  modport slave  (input req, we, req_x, req_y, wdata, output ack, rdata);
endinterface

// File: rtl/map_tile_ram.sv
// Single-port tile store, one-cycle synchronous read, read-before-write.
module map_tile_ram
  import map_pkg::*;
#(
  parameter int DEPTH  = 441,
  parameter int ADDR_W = 9
) (
  input  logic              clock_50,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  sprite_t           wr_data,
  output sprite_t           rd_data
);
  sprite_t mem [DEPTH];

  always_ff @(posedge clock_50) begin
    rd_data <= mem[addr];
    if (wr_en) mem[addr] <= wr_data;
  end
endmodule

// File: rtl/map_responder.sv
// Tile-map responder: round-robin arbiter over the movers, level init sweep,
// read/modify access to the tile RAM and remaining-dot bookkeeping.
//   state   | meaning
//   INIT    | sweeping walls/dots into the RAM, one tile per cycle
//   IDLE    | waiting for a request or a level restart
//   ACCESS  | RAM read of the granted tile in flight
//   RESPOND | ack + old tile value out, optional write applied
module map_responder
  import map_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int MAP_W       = MAP_W_DEFAULT,
  parameter int MAP_H       = MAP_H_DEFAULT
) (
  input  logic                 clock_50,
  input  logic                 reset,
  input  logic                 level_restart,
  map_responder_if.slave       bus,
  output logic [DOTS_W-1:0]    dots_left,
  output logic                 all_dots_eaten,
  output logic                 is_ready
);
  localparam int DEPTH     = MAP_W * MAP_H;
  localparam int ADDR_W    = $clog2(DEPTH);
  localparam int CLI_W     = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int INIT_DOTS = (MAP_W - 2) * (MAP_H - 2);
  localparam coord_t X_LAST = coord_t'(MAP_W - 1);
  localparam coord_t Y_LAST = coord_t'(MAP_H - 1);

  map_state_t              state;
  logic [CLI_W-1:0]        ptr;
  logic [ADDR_W-1:0]       lat_addr;
  logic                    lat_we;
  logic                    lat_oor;
  sprite_t                 lat_wdata;
  coord_t                  sweep_x;
  coord_t                  sweep_y;
  logic [ADDR_W-1:0]       sweep_addr;
  logic [NUM_CLIENTS-1:0]  ack_q;

  logic [CLI_W-1:0]  pick;
  coord_t            pick_x;
  coord_t            pick_y;
  logic              pick_oor;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  sprite_t           ram_wd;
  sprite_t           ram_rd;
  logic              border;

  // Search starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    pick = ptr;
    for (int i = NUM_CLIENTS; i >= 1; i--) begin
      if (bus.req[(int'(ptr) + i) % NUM_CLIENTS])
        pick = CLI_W'((int'(ptr) + i) % NUM_CLIENTS);
    end
  end

  assign pick_x   = bus.req_x[COORD_W*pick +: COORD_W];
  assign pick_y   = bus.req_y[COORD_W*pick +: COORD_W];
  assign pick_oor = (pick_x > X_LAST) || (pick_y > Y_LAST);
  assign border   = (sweep_x == '0) || (sweep_x == X_LAST) ||
                    (sweep_y == '0) || (sweep_y == Y_LAST);

  always_comb begin
    ram_addr = sweep_addr;
    ram_we   = 1'b0;
    ram_wd   = border ? WALL : DOT;
    case (state)
      INIT: ram_we = 1'b1;
      ACCESS, RESPOND: begin
        ram_addr = lat_addr;
        ram_wd   = lat_wdata;
        ram_we   = (state == RESPOND) && lat_we && !lat_oor;
      end
      default: ;
    endcase
  end

  map_tile_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clock_50 (clock_50),
    .addr     (ram_addr),
    .wr_en    (ram_we),
    .wr_data  (ram_wd),
    .rd_data  (ram_rd)
  );

  // Out-of-range tiles read as wall and are never written.
  assign bus.rdata      = (state == RESPOND) ? (lat_oor ? WALL : ram_rd) : EMPTY;
  assign bus.ack        = ack_q;
  assign all_dots_eaten = is_ready && (dots_left == '0);

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      ptr        <= CLI_W'(NUM_CLIENTS - 1);
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_oor    <= 1'b0;
      lat_wdata  <= EMPTY;
      sweep_x    <= '0;
      sweep_y    <= '0;
      sweep_addr <= '0;
      ack_q      <= '0;
      dots_left  <= '0;
      is_ready   <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state)
        INIT: begin
          sweep_addr <= sweep_addr + 1'b1;
          sweep_x    <= sweep_x + 1'b1;
          if (sweep_x == X_LAST) begin
            sweep_x <= '0;
            sweep_y <= sweep_y + 1'b1;
            if (sweep_y == Y_LAST) begin
              sweep_y    <= '0;
              sweep_addr <= '0;
              dots_left  <= DOTS_W'(INIT_DOTS);
              is_ready   <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        IDLE: begin
          if (level_restart) begin
            is_ready   <= 1'b0;
            dots_left  <= '0;
            sweep_x    <= '0;
            sweep_y    <= '0;
            sweep_addr <= '0;
            state      <= INIT;
          end else if (|bus.req) begin
            ptr       <= pick;
            lat_we    <= bus.we[pick];
            lat_wdata <= bus.wdata[SPRITE_W*pick +: SPRITE_W];
            lat_oor   <= pick_oor;
            lat_addr  <= pick_oor ? '0 : ADDR_W'(int'(pick_y) * MAP_W + int'(pick_x));
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          ack_q <= NUM_CLIENTS'(1) << ptr;
          state <= RESPOND;
        end
        RESPOND: begin
          if (ram_we) begin
            if (ram_rd == DOT && lat_wdata != DOT && dots_left != '0)
              dots_left <= dots_left - 1'b1;
            else if (ram_rd != DOT && lat_wdata == DOT && dots_left != '1)
              dots_left <= dots_left + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule
